// File: rtl/router_port_arb.sv
// Multi-channel input FIFOs feeding one output port through a two-state grant FSM.
// Round-robin or fixed-priority arbitration; one-cycle bubble between grants.
module router_port_arb_fifo #(
  parameter int PW    = 41,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [PW-1:0] din_i,
  output logic          full_o,
  output logic          nempty_o,
  output logic          ovf_o,
  output logic [PW-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          wr_en, rd_en;

  assign full_o   = (cnt_q == CW'(DEPTH));
  assign nempty_o = (cnt_q != '0);
  assign head_o   = mem_q[rd_q];
  // full is judged before the pop, so a push on a full channel drops even if popped
  assign wr_en    = push_i & ~full_o;
  assign rd_en    = pop_i & nempty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
      if (push_i && full_o) ovf_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_q] <= din_i;
  end
endmodule

module router_port_arb #(
  parameter int         NUM_CH     = 4,
  parameter int         pckg_sz    = 41,
  parameter int         fifo_depth = 8,
  parameter logic [7:0] bdcst      = {8{1'b1}},
  parameter int         ARB_MODE   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH*pckg_sz-1:0] data_in,
  input  logic [NUM_CH-1:0]         push,
  output logic [NUM_CH-1:0]         full,
  output logic [pckg_sz-1:0]        data_out,
  output logic                      pndng,
  input  logic                      pop,
  output logic                      bdcst_flag,
  output logic [$clog2(NUM_CH)-1:0] grant_ch,
  output logic [NUM_CH-1:0]         ovf
);
  localparam int GW = $clog2(NUM_CH);
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic                             state_q, state_d;
  logic [GW-1:0]                    grant_q, grant_d, rr_q, rr_d, sel;
  logic                             found, pop_go;
  logic [NUM_CH-1:0]                nempty, full_int, fifo_pop;
  logic [NUM_CH-1:0][pckg_sz-1:0]   head;
  int                               idx;
  logic [GW-1:0]                    idx_v;

  assign pop_go   = (state_q == ST_HOLD) & pop;
  assign fifo_pop = pop_go ? (NUM_CH'(1) << grant_q) : '0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    router_port_arb_fifo #(.PW(pckg_sz), .DEPTH(fifo_depth)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_i   (push[c]),
      .pop_i    (fifo_pop[c]),
      .din_i    (data_in[c*pckg_sz +: pckg_sz]),
      .full_o   (full_int[c]),
      .nempty_o (nempty[c]),
      .ovf_o    (ovf[c]),
      .head_o   (head[c])
    );
  end

  // First non-empty channel, scanning from rr_q (round-robin) or from 0 (fixed)
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    idx_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx   = (ARB_MODE == 1) ? i : (int'(rr_q) + i) % NUM_CH;
      idx_v = idx[GW-1:0];
      if (!found && nempty[idx_v]) begin
        found = 1'b1;
        sel   = idx_v;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: if (found) begin
        state_d = ST_HOLD;
        grant_d = sel;
      end
      default: if (pop) begin
        state_d = ST_IDLE;
        rr_d    = (grant_q == GW'(NUM_CH-1)) ? '0 : grant_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign pndng      = ~reset & (state_q == ST_HOLD);
  assign data_out   = pndng ? head[grant_q] : '0;
  assign bdcst_flag = pndng & (data_out[pckg_sz-1 -: 8] == bdcst);
  assign grant_ch   = grant_q;
  assign full       = reset ? '0 : full_int;
endmodule
